// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: register offsets, field positions, glyphs.
package seg_pkg;

  localparam logic [1:0] SEG_CONTENT0 = 2'd0;
  localparam logic [1:0] SEG_CONTENT1 = 2'd1;
  localparam logic [1:0] SEG_CTRL     = 2'd2;
  localparam logic [1:0] SEG_MODE     = 2'd3;

  localparam int unsigned SEG_EN_LSB    = 0;
  localparam int unsigned SEG_DP_LSB    = 16;
  localparam int unsigned SEG_BLINK_LSB = 0;
  localparam int unsigned SEG_BLANK_BIT = 31;

  // Active-high {g,f,e,d,c,b,a}; entry 15 first so index i selects glyph i.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scanner_if.sv
// Data-memory bus slice seen by the scanner peripheral.
interface seg_scanner_if;
  logic        sel;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, we, re, addr, din, input dout);
  modport slave  (input sel, we, re, addr, din, output dout);
endinterface

// File: rtl/led7seg.sv
// Hex nibble to active-high seven-segment pattern.
module led7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_en,
  output logic [6:0] o_seg
);

  assign o_seg = i_en ? SEG_GLYPHS[i_hex] : 7'h00;

endmodule

// File: rtl/seg_scanner.sv
// CPU-writable multiplexed seven-segment controller with enable, DP, blink and blank control.
module seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic              clock,
  input  logic              reset,
  seg_scanner_if.slave      bus,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg
);

  localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] r_content;
  logic [DIGITS-1:0]   r_en;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_blink;
  logic                r_blank;
  logic [IDX_W-1:0]    r_idx;
  logic [31:0]         r_scan_cnt;
  logic [31:0]         r_blink_cnt;
  logic                r_blink_ph;
  logic [31:0]         r_dout;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_seg;

  logic [63:0]         w_content;
  logic [15:0]         w_en;
  logic [15:0]         w_dp;
  logic [15:0]         w_blink;
  logic [4*DIGITS-1:0] w_content_nx;
  logic [31:0]         w_rd;
  logic                w_wr;
  logic                w_scan_tc;
  logic                w_blink_tc;
  logic [3:0]          w_idx;
  logic [3:0]          w_nib;
  logic [6:0]          w_glyph;
  logic                w_lit;
  logic [DIGITS-1:0]   w_an;
  logic                w_unused_addr;

  // Unstored digits are zero-extended so readback and scan see 0 for them.
  assign w_content     = 64'(r_content);
  assign w_en          = 16'(r_en);
  assign w_dp          = 16'(r_dp);
  assign w_blink       = 16'(r_blink);
  assign w_wr          = bus.sel & bus.we;
  assign w_scan_tc     = (r_scan_cnt == SCAN_DIV - 1);
  assign w_blink_tc    = (r_blink_cnt == BLINK_DIV - 1);
  assign w_idx         = 4'(r_idx);
  assign w_nib         = w_content[{w_idx, 2'b00} +: 4];
  assign w_unused_addr = ^bus.addr[1:0];

  always_comb begin
    w_rd = 32'h0;
    case (bus.addr[3:2])
      SEG_CONTENT0: w_rd = w_content[31:0];
      SEG_CONTENT1: w_rd = w_content[63:32];
      SEG_CTRL:     w_rd = {w_dp, w_en};
      default:      w_rd = {r_blank, 15'h0, w_blink};
    endcase
  end

  always_comb begin
    w_content_nx = r_content;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_wr && bus.addr[3:2] == ((i < 8) ? SEG_CONTENT0 : SEG_CONTENT1)) begin
        w_content_nx[4*i +: 4] = bus.din[4*(i%8) +: 4];
      end
    end
  end

  always_comb begin
    w_lit = w_en[w_idx] & ~r_blank & ~(w_blink[w_idx] & r_blink_ph);
    w_an  = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_lit && w_idx == 4'(i)) w_an[i] = 1'b0;
    end
  end

  led7seg u_led7seg (
    .i_hex (w_nib),
    .i_en  (1'b1),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_content <= '0;
      r_en      <= '1;
      r_dp      <= '0;
      r_blink   <= '0;
      r_blank   <= 1'b0;
      r_dout    <= 32'h0;
    end else begin
      r_content <= w_content_nx;
      if (w_wr && bus.addr[3:2] == SEG_CTRL) begin
        r_en <= bus.din[SEG_EN_LSB +: DIGITS];
        r_dp <= bus.din[SEG_DP_LSB +: DIGITS];
      end
      if (w_wr && bus.addr[3:2] == SEG_MODE) begin
        r_blink <= bus.din[SEG_BLINK_LSB +: DIGITS];
        r_blank <= bus.din[SEG_BLANK_BIT];
      end
      // Read mux sees pre-write state, so same-edge read returns the old value.
      if (bus.sel && bus.re) r_dout <= w_rd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scan_cnt  <= 32'h0;
      r_idx       <= '0;
      r_blink_cnt <= 32'h0;
      r_blink_ph  <= 1'b0;
      r_an        <= '1;
      r_seg       <= 8'hFF;
    end else begin
      r_scan_cnt <= w_scan_tc ? 32'h0 : r_scan_cnt + 32'h1;
      if (w_scan_tc) begin
        r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
      r_blink_cnt <= w_blink_tc ? 32'h0 : r_blink_cnt + 32'h1;
      if (w_blink_tc) r_blink_ph <= ~r_blink_ph;
      r_an  <= w_an;
      r_seg <= {~w_dp[w_idx], ~w_glyph};
    end
  end

  assign bus.dout = r_dout;
  assign an       = r_an;
  assign seg      = r_seg;

endmodule
